spi_byte_master: RTL and testbench



---
 rtl/spi_byte_master.sv | 157 +++++++++++++++
 tb/tb_spi_byte_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// Single-byte SPI master, mode 0, MSB first, one chip-select frame per byte.
// Optional build macro SPI_LOOPBACK_EN: RX samples internal mosi instead of the miso pin.
//
// state | meaning
// IDLE  | cs_n high, waiting for start
// SETUP | cs_n low, mosi shows bit 7, sclk low for one half-period
// SHIFT | 8 sclk cycles: sample on rise, advance mosi on fall
// HOLD  | sclk low, cs_n still low for one half-period, then done

module spi_byte_master #(
    parameter int SCLK_HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       done,
    output logic [7:0] data_out,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam int HW = $clog2(SCLK_HALF_PERIOD) + 1;
    localparam logic [HW-1:0] HALF_LOAD = HW'(SCLK_HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t       state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]   bit_q, bit_d;
    logic [7:0]   tx_q, tx_d;
    logic [7:0]   rx_q, rx_d;
    logic [7:0]   data_out_q, data_out_d;
    logic         sclk_q, sclk_d;
    logic         mosi_q, mosi_d;
    logic         cs_n_q, cs_n_d;
    logic         done_q, done_d;
    logic         half_tc;
    logic         rx_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit      = miso;
`endif

    // Half-period timer is a down-counter; terminal count marks each sclk edge.
    assign half_tc = (hcnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: if (half_tc) state_d = SHIFT;
            SHIFT: if (half_tc && sclk_q && (bit_q == 4'd7)) state_d = HOLD;
            HOLD:  if (half_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hcnt_d     = hcnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d   = data_in;
                    mosi_d = data_in[7];
                    cs_n_d = 1'b0;
                    hcnt_d = HALF_LOAD;
                end
            end
            SETUP: begin
                if (half_tc) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], rx_bit};
                    bit_d  = '0;
                    hcnt_d = HALF_LOAD;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (half_tc) begin
                    hcnt_d = HALF_LOAD;
                    if (sclk_q) begin
                        // Falling edge: present the next TX bit.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                        if (bit_q != 4'd7) bit_d = bit_q + 4'd1;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], rx_bit};
                    end
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (half_tc) begin
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign done     = done_q;
    assign data_out = data_out_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master (H=4) with a mode-0 slave model on the SPI pins.
// Build with SPI_LOOPBACK_EN defined to check the loopback variant.

module tb_spi_byte_master;

    localparam int H   = 4;
    localparam int LAT = 17 * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic       done;
    logic [7:0] data_out;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int frame_cnt = 0;
    int mosi_hi_cnt = 0;
    int e0;

    logic [7:0] slv_reply = 8'h00;
    logic [7:0] slv_rx;
    int         slv_bits;

    spi_byte_master #(.SCLK_HALF_PERIOD(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .done(done), .data_out(data_out), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!cs_n && mosi) mosi_hi_cnt <= mosi_hi_cnt + 1;
    end

    always @(negedge cs_n) frame_cnt = frame_cnt + 1;

    // Slave: capture mosi on sclk rise; bit index tracks which reply bit is on miso.
    always @(posedge sclk or negedge cs_n) begin
        if (sclk) begin
            slv_rx   = {slv_rx[6:0], mosi};
            slv_bits = slv_bits + 1;
        end else begin
            slv_bits = 0;
        end
    end

    always_comb begin
        miso = 1'b0;
        if (!cs_n && slv_bits < 8) miso = slv_reply[3'(7 - slv_bits)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] sent, input logic [7:0] reply);
`ifdef SPI_LOOPBACK_EN
        return sent;
`else
        return reply;
`endif
    endfunction

    task automatic kick(input logic [7:0] b, input logic [7:0] r);
        @(negedge clk);
        slv_reply = r;
        data_in   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        chk("cs_n_at_e0", 32'(cs_n), 32'd0);
        chk("mosi_at_e0", 32'(mosi), 32'(b[7]));
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] r, input bit inject);
        bit got;
        kick(b, r);
        if (inject) begin
            repeat (20) @(negedge clk);
            data_in = 8'hFF;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", 32'(cyc - e0), 32'(LAT));
        chk("cs_n_at_done", 32'(cs_n), 32'd1);
        chk("data_out", 32'(data_out), 32'(exp_rx(b, r)));
        chk("slave_bits", 32'(slv_bits), 32'd8);
        chk("slave_rx", 32'(slv_rx), 32'(b));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
    endtask

    logic [7:0] cmd_seq [10] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00,
                                 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        int f0, d0, m0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hA5, 8'h3C, 0);

        f0 = frame_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) send(cmd_seq[i], 8'(8'h81 + i * 8'h13), 0);
        chk("seq_frames", 32'(frame_cnt - f0), 32'd10);
        chk("seq_dones", 32'(done_cnt - d0), 32'd10);

        f0 = frame_cnt;
        d0 = done_cnt;
        m0 = mosi_hi_cnt;
        send(8'h00, 8'h77, 1);
        repeat (100) @(negedge clk);
        chk("ign_frames", 32'(frame_cnt - f0), 32'd1);
        chk("ign_dones", 32'(done_cnt - d0), 32'd1);
        chk("ign_mosi_high", 32'(mosi_hi_cnt - m0), 32'd0);
        chk("ign_cs_n_idle", 32'(cs_n), 32'd1);

        d0 = done_cnt;
        kick(8'h96, 8'h00);
        repeat (30) @(negedge clk);
        chk("abort_in_frame", 32'(cs_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'hC3, 8'h81, 0);

        send(8'h5A, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
